// File: rtl/hpdmc_initseq.sv
// SDRAM power-up initialisation sequencer: programs HPDMC timing registers over the
// CSR bus, runs PRECHARGE / 2x AUTO REFRESH / LOAD MODE, releases the controller and verifies it.
module hpdmc_initseq #(
  parameter logic        csr_addr = 1'b0,
  parameter logic [15:0] T_PWRUP  = 16'd10000,
  parameter logic [15:0] T_RP     = 16'd4,
  parameter logic [15:0] T_RFC    = 16'd10,
  parameter logic [15:0] T_MRD    = 16'd4,
  parameter logic [11:0] MODE     = 12'h022,
  parameter logic [12:0] TIM_CFG  = 13'h1412,
  parameter logic [10:0] REFI     = 11'd740
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [2:0]  csr_a,
  output logic        csr_we,
  output logic [15:0] csr_di,
  input  logic [15:0] csr_do
);

  // CSR protocol: a write happens in every cycle where csr_we is high (csr_a/csr_di
  // valid in that same cycle); reads have no strobe, csr_do returns one cycle after csr_a.
  typedef enum logic [3:0] {
    S_IDLE, S_WTIM, S_WREFI, S_WCKE, S_WAIT, S_PRE, S_REF,
    S_LMR, S_REL, S_RD, S_CHK, S_DONE
  } state_t;

  localparam logic [15:0] PRE_CMD = 16'h400B;
  localparam logic [15:0] REF_CMD = 16'h000D;
  localparam logic [15:0] LMR_CMD = {MODE, 4'hF};

  function automatic logic [15:0] at_least_one(input logic [15:0] v);
    return (v == 16'd0) ? 16'd1 : v;
  endfunction

  state_t      state_q, state_d;
  state_t      ret_q, ret_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ref_q, ref_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [1:0]  a_q, a_d;
  logic [15:0] di_q, di_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
      cnt_q   <= 16'd0;
      ref_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      a_q     <= 2'b00;
      di_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      a_q     <= a_d;
      di_q    <= di_d;
    end
  end

  // The registered outputs carry the action of the state being left at each edge.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    we_d    = 1'b0;
    a_d     = a_q;
    di_d    = 16'd0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          ref_d   = 1'b0;
          state_d = S_WTIM;
        end
      end
      S_WTIM: begin
        busy_d  = 1'b1;
        we_d    = 1'b1;
        a_d     = 2'd2;
        di_d    = {3'b000, TIM_CFG};
        state_d = S_WREFI;
      end
      S_WREFI: begin
        we_d    = 1'b1;
        a_d     = 2'd3;
        di_d    = {5'b00000, REFI};
        state_d = S_WCKE;
      end
      S_WCKE: begin
        we_d    = 1'b1;
        a_d     = 2'd0;
        di_d    = 16'h0007;
        cnt_d   = at_least_one(T_PWRUP);
        ret_d   = S_PRE;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= 16'd1) state_d = ret_q;
        else                cnt_d   = cnt_q - 16'd1;
      end
      S_PRE: begin
        we_d    = 1'b1;
        a_d     = 2'd1;
        di_d    = PRE_CMD;
        cnt_d   = at_least_one(T_RP);
        ret_d   = S_REF;
        state_d = S_WAIT;
      end
      S_REF: begin
        we_d    = 1'b1;
        a_d     = 2'd1;
        di_d    = REF_CMD;
        cnt_d   = at_least_one(T_RFC);
        ret_d   = ref_q ? S_LMR : S_REF;
        ref_d   = ~ref_q;
        state_d = S_WAIT;
      end
      S_LMR: begin
        we_d    = 1'b1;
        a_d     = 2'd1;
        di_d    = LMR_CMD;
        cnt_d   = at_least_one(T_MRD);
        ret_d   = S_REL;
        state_d = S_WAIT;
      end
      S_REL: begin
        we_d    = 1'b1;
        a_d     = 2'd0;
        di_d    = 16'h0004;
        state_d = S_RD;
      end
      S_RD: begin
        a_d     = 2'd0;
        state_d = S_CHK;
      end
      S_CHK: begin
        // The slave registers reg0 on this edge; it is sampled on the next one.
        state_d = S_DONE;
      end
      S_DONE: begin
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          err_d  = (csr_do[2:0] != 3'b100);
        end else if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          ref_d   = 1'b0;
          state_d = S_WTIM;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign csr_we = we_q;
  assign csr_a  = {csr_addr, a_q};
  assign csr_di = di_q;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Directed bench for hpdmc_initseq: per-cycle write trace tables, readback error,
// stray starts, async reset abort, restart from DONE and a zero T_RP instance.
module tb_hpdmc_initseq;

  typedef struct {
    int          cyc;
    logic [2:0]  a;
    logic [15:0] di;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n     = 1'b0;
  logic sel       = 1'b0;
  logic start_v   = 1'b0;
  logic force_err = 1'b0;
  logic start0, start1;
  assign start0 = start_v & ~sel;
  assign start1 = start_v & sel;

  logic        busy0, done0, err0, we0, busy1, done1, err1, we1;
  logic [2:0]  a0, a1;
  logic [15:0] di0, di1;
  logic [15:0] do0 = 16'd0;
  logic [15:0] do1 = 16'd0;

  hpdmc_initseq #(.T_PWRUP(16'd5), .T_RP(16'd2), .T_RFC(16'd3), .T_MRD(16'd2)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .err(err0), .csr_a(a0), .csr_we(we0), .csr_di(di0), .csr_do(do0));

  hpdmc_initseq #(.T_PWRUP(16'd5), .T_RP(16'd0), .T_RFC(16'd3), .T_MRD(16'd2)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .err(err1), .csr_a(a1), .csr_we(we1), .csr_di(di1), .csr_do(do1));

  // Slave models: registered read, independent of the sequencer reset.
  logic [15:0] regs0 [4];
  logic [15:0] regs1 [4];
  initial for (int i = 0; i < 4; i++) begin regs0[i] = 16'd0; regs1[i] = 16'd0; end

  always @(posedge clk) begin
    do0 <= force_err ? 16'h0005 : regs0[a0[1:0]];
    if (we0 && !a0[2]) regs0[a0[1:0]] <= di0;
    do1 <= force_err ? 16'h0005 : regs1[a1[1:0]];
    if (we1 && !a1[2]) regs1[a1[1:0]] <= di1;
  end

  logic        busy_m, done_m, err_m, we_m;
  logic [2:0]  a_m;
  logic [15:0] di_m;
  assign busy_m = sel ? busy1 : busy0;
  assign done_m = sel ? done1 : done0;
  assign err_m  = sel ? err1  : err0;
  assign we_m   = sel ? we1   : we0;
  assign a_m    = sel ? a1    : a0;
  assign di_m   = sel ? di1   : di0;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  wr_t cur   [8];
  wr_t tab_a [8];
  wr_t tab_b [8];

  // Entered at a negedge with the selected DUT in IDLE or DONE.
  task automatic run_seq(input int done_cyc, input bit exp_err, input int hold,
                         input bit stray, input string tag);
    logic        exp_we;
    int          idx;
    start_v = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("%s c0 done", tag), {15'd0, done_m}, 16'd0);
    chk($sformatf("%s c0 busy", tag), {15'd0, busy_m}, 16'd0);
    start_v = (hold > 1);
    for (int c = 1; c <= done_cyc + 1; c++) begin
      @(posedge clk);
      @(negedge clk);
      idx = -1;
      for (int k = 0; k < 8; k++) if (cur[k].cyc == c) idx = k;
      exp_we = (idx >= 0);
      chk($sformatf("%s c%0d we", tag, c), {15'd0, we_m}, {15'd0, exp_we});
      if (idx >= 0) begin
        chk($sformatf("%s c%0d a", tag, c), {13'd0, a_m}, {13'd0, cur[idx].a});
        chk($sformatf("%s c%0d di", tag, c), di_m, cur[idx].di);
      end else begin
        chk($sformatf("%s c%0d di idle", tag, c), di_m, 16'd0);
      end
      chk($sformatf("%s c%0d busy", tag, c), {15'd0, busy_m}, {15'd0, c < done_cyc});
      chk($sformatf("%s c%0d done", tag, c), {15'd0, done_m}, {15'd0, c >= done_cyc});
      chk($sformatf("%s c%0d err", tag, c), {15'd0, err_m}, {15'd0, exp_err && c >= done_cyc});
      start_v = (c < hold - 1) || (stray && (c == 5 || c == 15));
    end
    start_v = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " busy"},   {15'd0, busy0}, 16'd0);
    chk({tag, " done"},   {15'd0, done0}, 16'd0);
    chk({tag, " err"},    {15'd0, err0},  16'd0);
    chk({tag, " we"},     {15'd0, we0},   16'd0);
    chk({tag, " csr_a"},  {13'd0, a0},    16'd0);
    chk({tag, " csr_di"}, di0,            16'd0);
  endtask

  initial begin
    tab_a = '{'{1, 3'd2, 16'h1412}, '{2, 3'd3, 16'h02E4}, '{3, 3'd0, 16'h0007},
              '{9, 3'd1, 16'h400B}, '{12, 3'd1, 16'h000D}, '{16, 3'd1, 16'h000D},
              '{20, 3'd1, 16'h022F}, '{23, 3'd0, 16'h0004}};
    tab_b = '{'{1, 3'd2, 16'h1412}, '{2, 3'd3, 16'h02E4}, '{3, 3'd0, 16'h0007},
              '{9, 3'd1, 16'h400B}, '{11, 3'd1, 16'h000D}, '{15, 3'd1, 16'h000D},
              '{19, 3'd1, 16'h022F}, '{22, 3'd0, 16'h0004}};
    for (int k = 0; k < 8; k++) cur[k] = tab_a[k];

    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_seq(26, 1'b0, 1, 1'b0, "nominal");
    run_seq(26, 1'b0, 1, 1'b0, "restart");
    force_err = 1'b1;
    run_seq(26, 1'b1, 1, 1'b0, "rderr");
    force_err = 1'b0;
    run_seq(26, 1'b0, 1, 1'b1, "stray");

    // Abort during the wait that follows PRECHARGE (PRE written at cycle 9).
    start_v = 1'b1;
    @(posedge clk);
    #1 start_v = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("midseq busy", {15'd0, busy0}, 16'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async reset");
    @(negedge clk);
    chk_reset("held reset");
    rst_n = 1'b1;
    @(negedge clk);
    run_seq(26, 1'b0, 3, 1'b0, "after_rst");

    sel = 1'b1;
    for (int k = 0; k < 8; k++) cur[k] = tab_b[k];
    @(negedge clk);
    run_seq(25, 1'b0, 1, 1'b0, "rp0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
